// File: rtl/ascon_block_packer.sv
// ASCON rate-block packer: bytes in, 64-bit big-endian padded blocks out.
// One output register; the byte side stalls while a block is pending.
module ascon_block_packer #(
  parameter bit         SKIP_EMPTY = 1'b1,
  parameter logic [7:0] PAD_BYTE   = 8'h80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  input  logic        in_empty,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic [63:0] blk_data,
  output logic        blk_last,
  output logic [3:0]  blk_nbytes,
  output logic        msg_done
);

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    EMIT_PAD
  } state_t;

  localparam logic [63:0] PAD_BLK = {PAD_BYTE, 56'h0};

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [63:0] acc, acc_n;
  logic        pad_pend, pad_pend_n;
  logic [63:0] data_q, data_n;
  logic        last_q, last_n;
  logic [3:0]  nb_q, nb_n;
  logic        done_q, done_n;

  logic        take;
  logic        fin;
  logic        full;
  logic [63:0] ins;
  logic [63:0] acc_w;
  logic [63:0] pad_at;

  assign in_ready   = rst_n && (state == FILL);
  assign blk_valid  = (state != FILL);
  assign blk_data   = data_q;
  assign blk_last   = last_q;
  assign blk_nbytes = nb_q;
  assign msg_done   = done_q;

  assign take   = in_valid && in_ready;
  assign full   = (cnt == 3'd7);
  assign fin    = in_last || full;
  assign ins    = {in_byte, 56'h0} >> {cnt, 3'b000};
  assign acc_w  = acc | ins;
  // Only used when cnt < 7, so the wrapped shift is never selected.
  assign pad_at = PAD_BLK >> {cnt + 3'd1, 3'b000};

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    acc_n      = acc;
    pad_pend_n = pad_pend;
    data_n     = data_q;
    last_n     = last_q;
    nb_n       = nb_q;
    done_n     = 1'b0;
    if (clr) begin
      state_n    = FILL;
      cnt_n      = 3'd0;
      acc_n      = 64'h0;
      pad_pend_n = 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (take) begin
            unique case (1'b1)
              in_empty: begin
                if (SKIP_EMPTY) begin
                  done_n = 1'b1;
                end else begin
                  state_n = EMIT;
                  data_n  = PAD_BLK;
                  last_n  = 1'b1;
                  nb_n    = 4'd0;
                end
              end
              (!in_empty && fin): begin
                state_n    = EMIT;
                data_n     = full ? acc_w : (acc_w | pad_at);
                last_n     = in_last && !full;
                nb_n       = {1'b0, cnt} + 4'd1;
                pad_pend_n = in_last && full;
                acc_n      = 64'h0;
                cnt_n      = 3'd0;
              end
              (!in_empty && !fin): begin
                acc_n = acc_w;
                cnt_n = cnt + 3'd1;
              end
              default: ;
            endcase
          end
        end
        EMIT: begin
          if (blk_ready) begin
            if (pad_pend) begin
              state_n    = EMIT_PAD;
              pad_pend_n = 1'b0;
              data_n     = PAD_BLK;
              last_n     = 1'b1;
              nb_n       = 4'd0;
            end else begin
              state_n = FILL;
              done_n  = last_q;
            end
          end
        end
        EMIT_PAD: begin
          if (blk_ready) begin
            state_n = FILL;
            done_n  = 1'b1;
          end
        end
        default: state_n = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      cnt      <= 3'd0;
      acc      <= 64'h0;
      pad_pend <= 1'b0;
      data_q   <= 64'h0;
      last_q   <= 1'b0;
      nb_q     <= 4'd0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      acc      <= acc_n;
      pad_pend <= pad_pend_n;
      data_q   <= data_n;
      last_q   <= last_n;
      nb_q     <= nb_n;
      done_q   <= done_n;
    end
  end

endmodule
